// File: rtl/ls86_xor_arbiter.sv
// Round-robin arbiter that time-shares one external quad XOR gate among
// NREQ requesters. The winner's operands are latched onto the gate inputs.
// After SETTLE_CYC cycles the gate output is captured and returned with a
// one-cycle done pulse. Each captured result is also checked against an
// internal XOR, and any disagreement sets a sticky error flag.
module ls86_xor_arbiter #(
    parameter int NREQ       = 4,
    parameter int W          = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      y_out,
    output logic [W-1:0]      xa,
    output logic [W-1:0]      xb,
    input  logic [W-1:0]      xy,
    output logic              err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [W-1:0]    y_q, y_d;
    logic [W-1:0]    xa_q, xa_d;
    logic [W-1:0]    xb_q, xb_d;
    logic            err_q, err_d;

    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    logic [PW:0]     cand;
    logic [PW-1:0]   gidx_next;

    // Round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(j);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (!sel_found && req[cand[PW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PW-1:0];
            end
        end
        gidx_next = (gidx_q == PW'(NREQ-1)) ? '0 : gidx_q + 1'b1;
    end

    // Sequencer next-state: grant, wait for the gate to settle, capture, release.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        y_d     = y_q;
        xa_d    = xa_q;
        xb_d    = xb_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    gidx_d  = sel_idx;
                    gnt_d   = NREQ'(1) << sel_idx;
                    xa_d    = a_in[int'(sel_idx)*W +: W];
                    xb_d    = b_in[int'(sel_idx)*W +: W];
                    cnt_d   = 4'(SETTLE_CYC - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!req[gidx_q]) begin
                    // Requester withdrew before capture: drop the transaction.
                    gnt_d   = '0;
                    ptr_d   = gidx_next;
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    y_d     = xy;
                    done_d  = NREQ'(1) << gidx_q;
                    if (xy != (xa_q ^ xb_q))
                        err_d = 1'b1;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELEASE: begin
                if (!req[gidx_q]) begin
                    gnt_d   = '0;
                    ptr_d   = gidx_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset wins over any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            y_q     <= '0;
            xa_q    <= '0;
            xb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
            err_q   <= err_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign y_out = y_q;
    assign xa    = xa_q;
    assign xb    = xb_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ls86_xor_arbiter.sv
// Bench for ls86_xor_arbiter: three instances with settle times 1, 3 and 4,
// each fed by its own gate model. Instance 1's gate can be given stuck-at-0
// outputs to exercise the mismatch flag.
module tb_ls86_xor_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // settle = 1
    logic [3:0]  req1 = '0, gnt1, done1, y1, xa1, xb1, xy1, fault = '0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        err1;
    // settle = 3
    logic [3:0]  req3 = '0, gnt3, done3, y3, xa3, xb3, xy3;
    logic [15:0] a3 = '0, b3 = '0;
    logic        err3;
    // settle = 4
    logic [3:0]  req4 = '0, gnt4, done4, y4, xa4, xb4, xy4;
    logic [15:0] a4 = '0, b4 = '0;
    logic        err4;

    // Gate models; fault bits force the matching Y output low.
    assign xy1 = (xa1 ^ xb1) & ~fault;
    assign xy3 = xa3 ^ xb3;
    assign xy4 = xa4 ^ xb4;

    ls86_xor_arbiter #(.NREQ(4), .W(4), .SETTLE_CYC(1)) u1 (
        .clk(clk), .rst(rst), .req(req1), .a_in(a1), .b_in(b1), .gnt(gnt1),
        .done(done1), .y_out(y1), .xa(xa1), .xb(xb1), .xy(xy1), .err(err1));
    ls86_xor_arbiter #(.NREQ(4), .W(4), .SETTLE_CYC(3)) u3 (
        .clk(clk), .rst(rst), .req(req3), .a_in(a3), .b_in(b3), .gnt(gnt3),
        .done(done3), .y_out(y3), .xa(xa3), .xb(xb3), .xy(xy3), .err(err3));
    ls86_xor_arbiter #(.NREQ(4), .W(4), .SETTLE_CYC(4)) u4 (
        .clk(clk), .rst(rst), .req(req4), .a_in(a4), .b_in(b4), .gnt(gnt4),
        .done(done4), .y_out(y4), .xa(xa4), .xb(xb4), .xy(xy4), .err(err4));

    // Reference state for the randomized run.
    logic [3:0] r;
    logic [3:0] ea [4];
    logic [3:0] eb [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req1 = '0; req3 = '0; req4 = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Winner by the round-robin rule: first set bit starting at p, wrapping.
    function automatic int winner(input logic [3:0] m, input int p);
        for (int j = 0; j < 4; j++)
            if (m[(p + j) % 4]) return (p + j) % 4;
        return -1;
    endfunction

    task automatic raise(input logic [3:0] add);
        for (int i = 0; i < 4; i++)
            if (add[i] && !r[i]) begin
                ea[i] = 4'($urandom); eb[i] = 4'($urandom);
                a1[i*4 +: 4] = ea[i]; b1[i*4 +: 4] = eb[i];
            end
        r = r | add;
        req1 = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; req1 = 4'hF; a1 = 16'($urandom); b1 = 16'($urandom);
        tick(); tick();
        checks++;
        if ({gnt1, done1, y1, xa1, xb1, err1} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {gnt1, done1, y1, xa1, xb1, err1});
        end
        checks++;
        if ({gnt3, done3, gnt4, done4, err3, err4} !== 18'd0) begin
            errors++;
            $display("FAIL reset_others: got %h expected 0", {gnt3, done3, gnt4, done4, err3, err4});
        end
        req1 = '0; rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        a1[3:0] = 4'b1010; b1[3:0] = 4'b0110; req1 = 4'b0001;
        tick();
        checks++;
        if ({gnt1, xa1, xb1, done1} !== {4'b0001, 4'b1010, 4'b0110, 4'b0000}) begin
            errors++;
            $display("FAIL single_grant: got %h expected %h", {gnt1, xa1, xb1, done1}, {4'b0001, 4'b1010, 4'b0110, 4'b0000});
        end
        tick();
        checks++;
        if ({done1, y1, err1} !== {4'b0001, 4'b1100, 1'b0}) begin
            errors++;
            $display("FAIL single_done: got %h expected %h", {done1, y1, err1}, {4'b0001, 4'b1100, 1'b0});
        end
        req1 = '0;
        tick();
        checks++;
        if ({gnt1, done1} !== 8'd0) begin
            errors++;
            $display("FAIL single_release: got %h expected 0", {gnt1, done1});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] expy [4];
        int w;
        do_reset();
        a1 = {4'b1001, 4'b1111, 4'b0101, 4'b0000};
        b1 = {4'b0110, 4'b1111, 4'b0011, 4'b1111};
        expy[0] = 4'b1111; expy[1] = 4'b0110; expy[2] = 4'b0000; expy[3] = 4'b1111;
        req1 = 4'hF;
        for (int k = 0; k < 5; k++) begin
            w = k % 4;
            tick();
            checks++;
            if (gnt1 !== 4'(1 << w)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, gnt1, 4'(1 << w));
            end
            tick();
            checks++;
            if ({done1, y1} !== {4'(1 << w), expy[w]}) begin
                errors++;
                $display("FAIL rr_done[%0d]: got %h expected %h", k, {done1, y1}, {4'(1 << w), expy[w]});
            end
            req1[w] = 1'b0;
            tick();
            checks++;
            if (gnt1 !== 4'b0000) begin
                errors++;
                $display("FAIL rr_release[%0d]: got %b expected 0000", k, gnt1);
            end
            req1[w] = 1'b1;
        end
        req1 = '0;
    endtask

    task automatic test_settle();
        do_reset();
        a3[11:8] = 4'b0011; b3[11:8] = 4'b0101; req3 = 4'b0100;
        tick();
        checks++;
        if (gnt3 !== 4'b0100) begin
            errors++;
            $display("FAIL settle_grant: got %b expected 0100", gnt3);
        end
        for (int k = 1; k < 3; k++) begin
            tick();
            checks++;
            if (done3 !== 4'b0000) begin
                errors++;
                $display("FAIL settle_early_done[%0d]: got %b expected 0000", k, done3);
            end
        end
        tick();
        checks++;
        if ({done3, y3} !== {4'b0100, 4'b0110}) begin
            errors++;
            $display("FAIL settle_done: got %h expected %h", {done3, y3}, {4'b0100, 4'b0110});
        end
        req3 = '0;
        tick();
        checks++;
        if ({done3, gnt3} !== 8'd0) begin
            errors++;
            $display("FAIL settle_pulse_width: got %h expected 0", {done3, gnt3});
        end
    endtask

    task automatic test_abort();
        do_reset();
        // One completed transaction so y_out has a known nonzero value.
        a4[3:0] = 4'b0011; b4[3:0] = 4'b0000; req4 = 4'b0001;
        repeat (5) tick();
        req4 = '0;
        tick();
        checks++;
        if ({y4, gnt4} !== {4'b0011, 4'b0000}) begin
            errors++;
            $display("FAIL abort_setup: got %h expected %h", {y4, gnt4}, {4'b0011, 4'b0000});
        end
        a4[7:4] = 4'b1111; b4[7:4] = 4'b0001; req4 = 4'b0010;
        tick();
        checks++;
        if (gnt4 !== 4'b0010) begin
            errors++;
            $display("FAIL abort_grant: got %b expected 0010", gnt4);
        end
        tick(); tick();
        req4 = '0;
        tick();
        checks++;
        if ({gnt4, done4, y4} !== {4'b0000, 4'b0000, 4'b0011}) begin
            errors++;
            $display("FAIL abort_state: got %h expected %h", {gnt4, done4, y4}, {4'b0000, 4'b0000, 4'b0011});
        end
        tick();
        checks++;
        if (done4 !== 4'b0000) begin
            errors++;
            $display("FAIL abort_no_done: got %b expected 0000", done4);
        end
        req4 = 4'b1001;
        tick();
        checks++;
        if (gnt4 !== 4'b1000) begin
            errors++;
            $display("FAIL abort_next_ptr: got %b expected 1000", gnt4);
        end
        req4 = '0;
    endtask

    task automatic test_random();
        int p, w;
        logic [3:0] add;
        do_reset();
        p = 0; r = '0;
        for (int it = 0; it < 40; it++) begin
            add = 4'($urandom_range(0, 15));
            if ((r | add) == 4'd0) add = 4'(1 << $urandom_range(0, 3));
            raise(add);
            tick();
            w = winner(r, p);
            checks++;
            if ({gnt1, xa1, xb1} !== {4'(1 << w), ea[w], eb[w]}) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %h expected %h", it, {gnt1, xa1, xb1}, {4'(1 << w), ea[w], eb[w]});
            end
            // Operands are latched at grant; later changes must not matter.
            a1[w*4 +: 4] = 4'($urandom); b1[w*4 +: 4] = 4'($urandom);
            tick();
            checks++;
            if ({done1, y1, err1} !== {4'(1 << w), ea[w] ^ eb[w], 1'b0}) begin
                errors++;
                $display("FAIL rand_done[%0d]: got %h expected %h", it, {done1, y1, err1}, {4'(1 << w), ea[w] ^ eb[w], 1'b0});
            end
            r[w] = 1'b0;
            raise(4'($urandom) & ~4'(1 << w));
            tick();
            checks++;
            if ({gnt1, done1} !== 8'd0) begin
                errors++;
                $display("FAIL rand_release[%0d]: got %h expected 0", it, {gnt1, done1});
            end
            p = (w + 1) % 4;
        end
        req1 = '0; r = '0;
        tick(); tick();
    endtask

    task automatic test_faulty_gate();
        fault = 4'b1000;
        a1[3:0] = 4'b1000; b1[3:0] = 4'b0000; req1 = 4'b0001;
        tick(); tick();
        checks++;
        if ({done1, y1, err1} !== {4'b0001, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL fault_detect: got %h expected %h", {done1, y1, err1}, {4'b0001, 4'b0000, 1'b1});
        end
        req1 = '0;
        tick();
        fault = '0;
        a1[7:4] = 4'b0101; b1[7:4] = 4'b0011; req1 = 4'b0010;
        tick(); tick();
        checks++;
        if ({done1, y1, err1} !== {4'b0010, 4'b0110, 1'b1}) begin
            errors++;
            $display("FAIL fault_sticky: got %h expected %h", {done1, y1, err1}, {4'b0010, 4'b0110, 1'b1});
        end
        req1 = '0;
        tick(); tick();
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky_idle: got %b expected 1", err1);
        end
    endtask

    task automatic test_reset_mid_op();
        // err is still set from the faulty-gate run; no reset in between.
        a1[11:8] = 4'b1100; b1[11:8] = 4'b0101; req1 = 4'b0100;
        tick(); tick();
        req1 = '0;
        tick();
        a1[15:12] = 4'b0111; b1[15:12] = 4'b0001; req1 = 4'b1000;
        tick();
        checks++;
        if (gnt1 !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_grant: got %b expected 1000", gnt1);
        end
        rst = 1'b1; req1 = '0;
        tick();
        checks++;
        if ({gnt1, done1, y1, xa1, xb1, err1} !== 21'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 0", {gnt1, done1, y1, xa1, xb1, err1});
        end
        rst = 1'b0; req1 = 4'b1010;
        tick();
        checks++;
        if (gnt1 !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_ptr: got %b expected 0010", gnt1);
        end
        req1 = '0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_settle();
        test_abort();
        test_random();
        test_faulty_gate();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
